// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, TX state encoding and a parity helper.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package uart_pkg;

    // Parity modes, selected per instance by the PARITY parameter
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Transmit FSM states; the receiver reuses this encoding
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_POP    = 3'd1,
        TX_LOAD   = 3'd2,
        TX_START  = 3'd3,
        TX_DATA   = 3'd4,
        TX_PARITY = 3'd5,
        TX_STOP   = 3'd6
    } tx_state_t;

    // Parity bit for up to 8 data bits; narrower words are zero-extended,
    // which leaves the XOR reduction unchanged
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        logic p;
        p = 1'b0;
        if (mode == PAR_ODD) begin
            p = ~^data;
        end else if (mode == PAR_EVEN) begin
            p = ^data;
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: free-running 0..CLKS_PER_BIT-1 counter with a synchronous clear.
// Latency: o_Tick is a flop, high during the final cycle of each bit period.
// Backpressure: none; i_Clr holds the count at zero.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Clr,
    output logic o_Tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise wrap at the end of the bit period
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (i_Clr || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    // Counter register; the tick flop looks ahead so it lines up with the last cycle
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cnt_q  <= '0;
            o_Tick <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            o_Tick <= (cnt_d == CNT_LAST);
        end
    end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that pops words from an upstream FIFO and serialises them onto o_Tx.
// Latency: start bit begins 3 cycles after the idle cycle that sees a non-empty FIFO.
// Backpressure: pops only when idle, enabled and the FIFO is non-empty; never underflows it.
module uart_tx_fifo_drain
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_En,
    input  logic                 i_FifoEmpty,
    output logic                 o_FifoRdEn,
    input  logic [DATA_BITS-1:0] i_FifoRdData,
    output logic                 o_Tx,
    output logic                 o_Busy,
    output logic                 o_FrameDone
);

    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic                 par_q, par_d;
    logic                 tx_d, busy_d, rd_d;
    logic                 baud_tick;
    logic                 baud_clr;

    // Hold the bit timer at zero outside the serial states so START always gets a full period
    assign baud_clr = (state_q == TX_IDLE) || (state_q == TX_POP) || (state_q == TX_LOAD);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_Clr  (baud_clr),
        .o_Tick (baud_tick)
    );

    // Frame end is decoded from flops only: state, tick and stop-bit count
    assign o_FrameDone = (state_q == TX_STOP) && baud_tick && (stop_q == STOP_LAST);

    // State register
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= TX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, datapath updates, and the output values for the coming cycle
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        par_d   = par_q;
        case (state_q)
            TX_IDLE: begin
                if (i_En && !i_FifoEmpty) begin
                    state_d = TX_POP;
                end
            end
            TX_POP: begin
                state_d = TX_LOAD;
            end
            TX_LOAD: begin
                shift_d = i_FifoRdData;
                par_d   = parity_bit(8'(i_FifoRdData), PARITY);
                bit_d   = '0;
                stop_d  = 1'b0;
                state_d = TX_START;
            end
            TX_START: begin
                if (baud_tick) begin
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == DATA_LAST) begin
                        state_d = (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
                    end
                end
            end
            TX_PARITY: begin
                if (baud_tick) begin
                    state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (baud_tick) begin
                    if (stop_q == STOP_LAST) begin
                        state_d = TX_IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        case (state_d)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = shift_d[0];
            TX_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != TX_IDLE);
        rd_d   = (state_d == TX_POP);
    end

    // Datapath and output registers; reset abandons any frame in flight
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            shift_q    <= '0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            par_q      <= 1'b0;
            o_Tx       <= 1'b1;
            o_Busy     <= 1'b0;
            o_FifoRdEn <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            stop_q     <= stop_d;
            par_q      <= par_d;
            o_Tx       <= tx_d;
            o_Busy     <= busy_d;
            o_FifoRdEn <= rd_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: three instances (no, odd, even parity), each fed by a depth-4 FIFO.
// Latency: a frame-level model predicts every output per cycle from the words written.
// Backpressure: the FIFO flags underflow if a read arrives while it is empty.
module tb_uart_tx_fifo_drain;

    logic       i_Clk = 1'b0;
    logic       rst   = 1'b0;
    logic [2:0] en    = 3'b111;
    logic [2:0] empty;
    logic [2:0] rd_en, tx, busy, done;
    logic [2:0] wr_en = 3'b000;
    logic [7:0] rd_dat [3] = '{8'h00, 8'h00, 8'h00};
    logic [7:0] wr_dat [3] = '{8'h00, 8'h00, 8'h00};

    always #5 i_Clk = ~i_Clk;

    uart_tx_fifo_drain #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .i_Clk(i_Clk), .i_Rst(rst), .i_En(en[0]), .i_FifoEmpty(empty[0]), .o_FifoRdEn(rd_en[0]),
        .i_FifoRdData(rd_dat[0]), .o_Tx(tx[0]), .o_Busy(busy[0]), .o_FrameDone(done[0]));
    uart_tx_fifo_drain #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut1 (
        .i_Clk(i_Clk), .i_Rst(rst), .i_En(en[1]), .i_FifoEmpty(empty[1]), .o_FifoRdEn(rd_en[1]),
        .i_FifoRdData(rd_dat[1]), .o_Tx(tx[1]), .o_Busy(busy[1]), .o_FrameDone(done[1]));
    uart_tx_fifo_drain #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut2 (
        .i_Clk(i_Clk), .i_Rst(rst), .i_En(en[2]), .i_FifoEmpty(empty[2]), .o_FifoRdEn(rd_en[2]),
        .i_FifoRdData(rd_dat[2]), .o_Tx(tx[2]), .o_Busy(busy[2]), .o_FrameDone(done[2]));

    // ---------------- upstream FIFOs (depth 4, registered read data) ----------------
    logic [7:0] mem [3][4];
    int         fcnt [3] = '{0, 0, 0};
    int         rptr [3] = '{0, 0, 0};
    int         wptr [3] = '{0, 0, 0};
    logic [2:0] uflow = 3'b000;

    always_comb begin
        for (int i = 0; i < 3; i++) empty[i] = (fcnt[i] == 0);
    end

    always @(posedge i_Clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rd_en[i]) begin
                if (fcnt[i] == 0) uflow[i] <= 1'b1;
                else begin
                    rd_dat[i] <= mem[i][rptr[i]];
                    rptr[i]   <= (rptr[i] + 1) % 4;
                end
            end
            if (wr_en[i] && fcnt[i] < 4) begin
                mem[i][wptr[i]] <= wr_dat[i];
                wptr[i]         <= (wptr[i] + 1) % 4;
            end
            fcnt[i] <= fcnt[i] + ((wr_en[i] && fcnt[i] < 4) ? 1 : 0) - ((rd_en[i] && fcnt[i] > 0) ? 1 : 0);
        end
    end

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    int         t        = 0;
    logic [7:0] mq_mem  [3][64];
    int         mq_head [3] = '{0, 0, 0};
    int         mq_tail [3] = '{0, 0, 0};
    int         f_k     [3] = '{-100000, -100000, -100000};
    int         f_len   [3] = '{10, 10, 10};
    logic [15:0] f_bits [3] = '{16'h0, 16'h0, 16'h0};
    int         m_free  [3] = '{0, 0, 0};
    int         rd_cnt  [3] = '{0, 0, 0};
    int         done_cnt[3] = '{0, 0, 0};

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, t);
        end
    endtask

    // Per-cycle model: a frame is a list of bit values, each held 4 cycles, preceded by
    // two idle-high cycles (pop, load); instance i uses parity mode i.
    initial begin
        int d, L, n;
        logic [7:0] w;
        logic [15:0] bits;
        logic etx, ebusy, erd, edone;
        forever begin
            @(negedge i_Clk);
            t++;
            for (int i = 0; i < 3; i++) begin
                if (rst) begin
                    etx = 1'b1; ebusy = 1'b0; erd = 1'b0; edone = 1'b0;
                end else begin
                    d     = t - f_k[i];
                    L     = f_len[i];
                    erd   = (d == 0);
                    ebusy = (d >= 0) && (d < 2 + 4 * L);
                    edone = (d == 1 + 4 * L);
                    etx   = ((d >= 2) && (d < 2 + 4 * L)) ? f_bits[i][(d - 2) / 4] : 1'b1;
                end
                check($sformatf("tx%0d", i), tx[i], etx);
                check($sformatf("busy%0d", i), busy[i], ebusy);
                check($sformatf("rden%0d", i), rd_en[i], erd);
                check($sformatf("done%0d", i), done[i], edone);
                if (rd_en[i]) rd_cnt[i]++;
                if (done[i]) done_cnt[i]++;
                // decide whether the next clock edge starts a frame
                if (rst) begin
                    m_free[i] = t + 1;
                    f_k[i]    = -100000;
                end else if (t >= m_free[i] && en[i] && !empty[i] && mq_head[i] != mq_tail[i]) begin
                    w = mq_mem[i][mq_head[i] % 64];
                    mq_head[i]++;
                    bits = 16'h0;
                    bits[8:1] = w;
                    n = 9;
                    if (i == 1) begin bits[9] = ~^w; n = 10; end
                    if (i == 2) begin bits[9] = ^w;  n = 10; end
                    bits[n]   = 1'b1;
                    f_bits[i] = bits;
                    f_len[i]  = n + 1;
                    f_k[i]    = t + 1;
                    m_free[i] = t + 3 + 4 * (n + 1);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic write(input logic [2:0] mask, input logic [7:0] v);
        step();
        for (int i = 0; i < 3; i++) begin
            if (mask[i]) begin
                wr_en[i]  = 1'b1;
                wr_dat[i] = v;
                mq_mem[i][mq_tail[i] % 64] = v;
                mq_tail[i]++;
            end
        end
        step();
        wr_en = 3'b000;
    endtask

    task automatic wait_fall(input int i);
        int k;
        k = 0;
        while (tx[i] !== 1'b0 && k < 300) begin
            @(negedge i_Clk);
            k++;
        end
        if (k >= 300) check($sformatf("fall_timeout%0d", i), tx[i], 0);
    endtask

    task automatic wait_done(input int i);
        int k;
        k = 0;
        while (done[i] !== 1'b1 && k < 300) begin
            @(negedge i_Clk);
            k++;
        end
        if (k >= 300) check($sformatf("done_timeout%0d", i), done[i], 1);
    endtask

    // ---------------- directed and random tests ----------------
    initial begin
        logic [9:0] got;
        logic [9:0] exp_a5;
        logic [7:0] v;
        logic [7:0] t3v [3];
        int rd0, dn0, len, g, lows;
        logic p1, p2;

        exp_a5 = 10'b1101001010;
        t3v    = '{8'h11, 8'h22, 8'h33};

        #1 rst = 1'b1;
        repeat (3) step();
        check("reset_tx", tx, 7);
        check("reset_busy", busy, 0);
        check("reset_rden", rd_en, 0);
        check("reset_done", done, 0);
        rst = 1'b0;
        repeat (3) step();

        // 1: single word, no parity
        rd0 = rd_cnt[0]; dn0 = done_cnt[0];
        write(3'b001, 8'hA5);
        wait_fall(0);
        for (int n = 0; n < 10; n++) begin
            got[n] = tx[0];
            repeat (4) @(negedge i_Clk);
        end
        check("t1_bits", got, exp_a5);
        check("t1_rden_count", rd_cnt[0] - rd0, 1);
        check("t1_done_count", done_cnt[0] - dn0, 1);
        check("t1_fifo_empty", empty[0], 1);

        // 2: parity bit and frame length for 0x07
        write(3'b110, 8'h07);
        wait_fall(2);
        len = 0; p1 = 1'b0; p2 = 1'b0;
        while (len < 200) begin
            len++;
            if (len == 37) begin p1 = tx[1]; p2 = tx[2]; end
            if (done[2]) break;
            @(negedge i_Clk);
        end
        check("t2_even_parity", p2, 1);
        check("t2_odd_parity", p1, 0);
        check("t2_frame_len", len, 44);

        // 3: three words back to back
        repeat (10) step();
        rd0 = rd_cnt[0];
        write(3'b001, 8'h11);
        write(3'b001, 8'h22);
        write(3'b001, 8'h33);
        for (int f = 0; f < 3; f++) begin
            wait_fall(0);
            v = 8'h00;
            for (int b = 0; b < 8; b++) begin
                repeat (4) @(negedge i_Clk);
                v[b] = tx[0];
            end
            check($sformatf("t3_data%0d", f), v, t3v[f]);
            wait_done(0);
            if (f < 2) begin
                @(negedge i_Clk);
                g = 0;
                while (tx[0] && g < 50) begin
                    g++;
                    @(negedge i_Clk);
                end
                check($sformatf("t3_gap%0d", f), g, 3);
            end
        end
        check("t3_rden_count", rd_cnt[0] - rd0, 3);
        check("t3_underflow", uflow[0], 0);

        // 4: disabled with a word waiting, then enabled
        repeat (10) step();
        en[0] = 1'b0;
        rd0 = rd_cnt[0];
        write(3'b001, 8'h55);
        lows = 0;
        repeat (100) begin
            @(negedge i_Clk);
            if (!tx[0]) lows++;
        end
        check("t4_tx_low_cycles", lows, 0);
        check("t4_no_pop", rd_cnt[0] - rd0, 0);
        step();
        en[0] = 1'b1;
        len = 0;
        @(negedge i_Clk);
        while (tx[0] && len < 50) begin
            len++;
            @(negedge i_Clk);
        end
        check("t4_start_latency", len, 3);
        wait_done(0);

        // 5: reset during data bit 3 of 0xF0
        repeat (5) step();
        write(3'b001, 8'hF0);
        wait_fall(0);
        repeat (17) @(negedge i_Clk);
        @(posedge i_Clk);
        #1 rst = 1'b1;
        #1;
        check("t5_tx_in_reset", tx[0], 1);
        check("t5_busy_in_reset", busy[0], 0);
        step();
        rst = 1'b0;
        rd0 = rd_cnt[0];
        repeat (30) step();
        check("t5_no_pop_after", rd_cnt[0] - rd0, 0);
        check("t5_idle_after", busy[0], 0);

        // 6: enable drops during DATA
        rd0 = rd_cnt[0];
        write(3'b001, 8'h3C);
        write(3'b001, 8'h81);
        write(3'b001, 8'h42);
        wait_fall(0);
        v = 8'h00;
        for (int b = 0; b < 8; b++) begin
            repeat (4) @(negedge i_Clk);
            v[b] = tx[0];
            if (b == 1) #1 en[0] = 1'b0;
        end
        check("t6_data", v, 8'h3C);
        wait_done(0);
        repeat (60) @(negedge i_Clk);
        check("t6_single_pop", rd_cnt[0] - rd0, 1);
        check("t6_fifo_left", fcnt[0], 2);

        // random: writes and enable toggles on all three instances
        for (int c = 0; c < 3000; c++) begin
            step();
            wr_en = 3'b000;
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 39) == 0) en[i] = ~en[i];
                if (fcnt[i] < 3 && $urandom_range(0, 29) == 0) begin
                    wr_en[i]  = 1'b1;
                    wr_dat[i] = 8'($urandom_range(0, 255));
                    mq_mem[i][mq_tail[i] % 64] = wr_dat[i];
                    mq_tail[i]++;
                end
            end
        end
        step();
        wr_en = 3'b000;
        en    = 3'b111;
        repeat (300) step();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("final_fifo_drained%0d", i), fcnt[i], 0);
            check($sformatf("final_underflow%0d", i), uflow[i], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
